time_set_controller: RTL
========================

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 Parameter REPEAT_DELAY, default 25000000: clock cycles btn_inc must be held before auto-repeat starts.
REQ-002 Parameter REPEAT_RATE, default 5000000: clock cycles between auto-repeat increments.
REQ-003 Parameter TIMEOUT, default 500000000: idle clock cycles in an edit state before edit is abandoned.
REQ-004 clock  input  1  single clock; all state SHALL be on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 btn_mode  input  1  raw, debounced, asynchronous mode button; high = pressed.
REQ-007 btn_inc  input  1  raw, debounced, asynchronous increment button; high = pressed.
REQ-008 cur_hour  input  5  running hour from the time counter, 0..23.
REQ-009 cur_minute  input  6  running minute from the time counter, 0..59.
REQ-010 set_hour  output  5  hour value to load into the time counter.
REQ-011 set_minute  output  6  minute value to load into the time counter.
REQ-012 load  output  1  one-cycle strobe: time counter SHALL take set_hour/set_minute.
REQ-013 field_sel  output  2  00 = none, 01 = hour being edited, 10 = minute being edited; drives display blanking.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then rising-edge detection on the synchronized signal.
REQ-015 A button rising at the input SHALL take effect on the 3rd rising clock edge after it is sampled high.
REQ-016 FSM states SHALL be RUN, EDIT_HOUR, EDIT_MIN, COMMIT.
REQ-017 RUN: a mode edge SHALL copy cur_hour/cur_minute into set_hour/set_minute and enter EDIT_HOUR.
REQ-018 EDIT_HOUR transitions:
- inc event: set_hour +1, 23 wraps to 0;
- mode edge: enter EDIT_MIN.
REQ-019 EDIT_MIN transitions:
- inc event: set_minute +1, 59 wraps to 0; set_hour unchanged;
- mode edge: enter COMMIT.
REQ-020 COMMIT SHALL last exactly one cycle with load=1, then return to RUN; load SHALL be 0 in every other state.
REQ-021 Inc events SHALL be ignored in RUN and COMMIT.
REQ-022 Auto-repeat:
- btn_inc held (synchronized) for REPEAT_DELAY cycles after its edge SHALL generate an inc event;
- further events follow every REPEAT_RATE cycles while held;
- release SHALL clear the repeat counter.
REQ-023 Mode edge and inc event in the same cycle: the mode transition SHALL be taken and the inc event discarded.
REQ-024 An idle counter SHALL reset on any button edge or inc event; reaching TIMEOUT in EDIT_HOUR or EDIT_MIN SHALL return to RUN with no load pulse.
REQ-025 set_hour/set_minute SHALL hold their last values in RUN.
REQ-026 field_sel SHALL be 01 in EDIT_HOUR, 10 in EDIT_MIN, and 00 otherwise.
REQ-027 Out-of-range cur_hour (>23) or cur_minute (>59) captured on entry SHALL wrap to 0 on the next inc event.

Reset
REQ-028 reset low SHALL immediately force:
- state RUN;
- set_hour=0, set_minute=0, load=0, field_sel=00;
- synchronizers, edge registers, repeat counter and idle counter to 0.
REQ-029 Reset asserted mid-edit SHALL abandon the edit with no load pulse.
REQ-030 The first edge after reset release SHALL NOT produce a spurious button edge when a button is already held; synchronizer reset 0 plus held high SHALL count as one edge.

Structure
REQ-031 Shared package alarm_clock_pkg SHALL hold the state enum, MAX_HOUR=23, MAX_MINUTE=59 and the field_sel encodings.
REQ-032 Sub-module button_conditioner (synchronizer, edge detect, optional auto-repeat enable) SHALL be instantiated once per button.

Verification (REPEAT_DELAY=8, REPEAT_RATE=4, TIMEOUT=64)
REQ-033 Entry and commit: cur=13:45, then mode, 2 inc, mode, 3 inc, mode -> single load pulse with set=15:48, field_sel back to 00.
REQ-034 Hour wrap: cur=22:10, then mode, 3 inc -> set_hour sequence 23, 0, 1.
REQ-035 Auto-repeat: in EDIT_MIN from 58, hold btn_inc 20 cycles past its edge -> increments at edge, +8, +12, +16, +20; minute sequence 59, 0, 1, 2, 3.
REQ-036 Timeout and reset:
- in EDIT_HOUR, 64 idle cycles -> state RUN, load never 1;
- separately, reset low mid-EDIT_MIN -> all outputs 0 asynchronously.
REQ-037 Collision: mode and inc rising in the same cycle in EDIT_HOUR -> EDIT_MIN entered, set_hour unchanged.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared definitions for the alarm-clock time-setting logic.
// Holds the FSM state codes, time-field limits, field_sel encodings and
// wrap-around increment helpers used by time_set_controller.
package alarm_clock_pkg;

    localparam logic [4:0] MAX_HOUR   = 5'd23;
    localparam logic [5:0] MAX_MINUTE = 6'd59;

    // State codes kept as plain constants so legacy code can compare raw bits.
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN       = 2'd0;
    localparam state_t ST_EDIT_HOUR = 2'd1;
    localparam state_t ST_EDIT_MIN  = 2'd2;
    localparam state_t ST_COMMIT    = 2'd3;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_HOUR = 2'b01;
    localparam logic [1:0] FIELD_MIN  = 2'b10;

    // ">=" rather than "==" so an out-of-range captured value wraps to 0.
    function automatic logic [4:0] next_hour(input logic [4:0] hour);
        return (hour >= MAX_HOUR) ? 5'd0 : hour + 5'd1;
    endfunction

    function automatic logic [5:0] next_minute(input logic [5:0] minute);
        return (minute >= MAX_MINUTE) ? 6'd0 : minute + 6'd1;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Button conditioner: 2-flop synchronizer, rising-edge detect and optional
// auto-repeat.
// Ports:
//   clock, reset    - clock, asynchronous active-low reset
//   btn             - raw debounced button, high = pressed
//   rise            - one-cycle pulse on the synchronized rising edge
//   evt             - rise, plus auto-repeat pulses while held (if enabled)
module button_conditioner #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise,
    output logic evt
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             repeating_q, repeating_d;
    logic             repeat_evt;

    // prev_q resets to 0 so a button held through reset release yields one edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            cnt_q       <= '0;
            repeating_q <= 1'b0;
        end else begin
            sync1_q     <= btn;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            cnt_q       <= cnt_d;
            repeating_q <= repeating_d;
        end
    end

    assign rise = sync2_q & ~prev_q;

    // cnt_q equals the number of cycles since the edge (or since the last
    // repeat), so the first repeat lands REPEAT_DELAY cycles after the edge.
    always_comb begin
        cnt_d       = cnt_q;
        repeating_d = repeating_q;
        repeat_evt  = 1'b0;
        if (!REPEAT_EN || !sync2_q) begin
            cnt_d       = '0;
            repeating_d = 1'b0;
        end else if (rise) begin
            cnt_d       = CNT_W'(1);
            repeating_d = 1'b0;
        end else if ((!repeating_q && cnt_q == CNT_W'(REPEAT_DELAY)) ||
                     ( repeating_q && cnt_q == CNT_W'(REPEAT_RATE))) begin
            repeat_evt  = 1'b1;
            cnt_d       = CNT_W'(1);
            repeating_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign evt = rise | repeat_evt;

endmodule

// File: rtl/time_set_controller.sv
// Time-setting controller for the alarm clock.
// Mode button walks RUN -> EDIT_HOUR -> EDIT_MIN -> COMMIT -> RUN; the inc
// button (with auto-repeat) advances the field being edited. COMMIT pulses
// load for one cycle. Edits abandon after TIMEOUT idle cycles.
// Ports:
//   clock, reset           - clock, asynchronous active-low reset
//   btn_mode, btn_inc      - raw debounced buttons, high = pressed
//   cur_hour, cur_minute   - running time, captured on edit entry
//   set_hour, set_minute   - value to load into the time counter
//   load                   - one-cycle load strobe
//   field_sel              - field under edit, for display blanking
module time_set_controller
    import alarm_clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned TIMEOUT      = 500000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_minute,
    output logic [4:0] set_hour,
    output logic [5:0] set_minute,
    output logic       load,
    output logic [1:0] field_sel
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic              mode_rise, mode_evt, inc_rise, inc_evt;
    logic              activity, timeout;
    state_t            state_q, state_d;
    logic [4:0]        hour_q, hour_d;
    logic [5:0]        minute_q, minute_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    button_conditioner #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .REPEAT_EN    (1'b0)
    ) u_mode_cond (
        .clock (clock),
        .reset (reset),
        .btn   (btn_mode),
        .rise  (mode_rise),
        .evt   (mode_evt)
    );

    button_conditioner #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .REPEAT_EN    (1'b1)
    ) u_inc_cond (
        .clock (clock),
        .reset (reset),
        .btn   (btn_inc),
        .rise  (inc_rise),
        .evt   (inc_evt)
    );

    assign activity = mode_rise | mode_evt | inc_rise | inc_evt;
    assign timeout  = (idle_q == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            hour_q   <= '0;
            minute_q <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            idle_q   <= idle_d;
        end
    end

    // Mode edges take priority over inc events in the same cycle.
    always_comb begin
        state_d  = state_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        idle_d   = activity ? '0 : idle_q + IDLE_W'(1);
        case (state_q)
            ST_RUN: begin
                idle_d = '0;
                if (mode_rise) begin
                    hour_d   = cur_hour;
                    minute_d = cur_minute;
                    state_d  = ST_EDIT_HOUR;
                end
            end
            ST_EDIT_HOUR: begin
                if (mode_rise)    state_d = ST_EDIT_MIN;
                else if (inc_evt) hour_d  = next_hour(hour_q);
                else if (timeout) state_d = ST_RUN;
            end
            ST_EDIT_MIN: begin
                if (mode_rise)    state_d  = ST_COMMIT;
                else if (inc_evt) minute_d = next_minute(minute_q);
                else if (timeout) state_d  = ST_RUN;
            end
            default: begin
                idle_d  = '0;
                state_d = ST_RUN;
            end
        endcase
    end

    assign set_hour   = hour_q;
    assign set_minute = minute_q;
    assign load       = (state_q == ST_COMMIT);

    always_comb begin
        case (state_q)
            ST_EDIT_HOUR: field_sel = FIELD_HOUR;
            ST_EDIT_MIN:  field_sel = FIELD_MIN;
            default:      field_sel = FIELD_NONE;
        endcase
    end

endmodule
